// File: rtl/cve2_obi_arbiter.sv
// ---------------------------------------------------------------------------
// cve2_obi_arbiter
//
// Purpose:
//   Shares one OBI memory port between the instruction-fetch and LSU
//   requesters. Data normally wins arbitration. Once a requester has been
//   presented to memory without a grant, it keeps the port until it is
//   granted. The IDs of accepted transactions go into a small FIFO, and each
//   memory response is steered back to the requester that issued it.
//
// Optional feature:
//   CVE2_ARB_STARVE_GUARD_EN - when defined, a starvation counter limits how
//   many consecutive data grants can be given while a fetch is waiting. When
//   it is undefined, data has strict priority.
//
// Parameters:
//   MaxOutstanding - accepted but unanswered transactions (power of two, >=1)
//   StarveLimit    - consecutive data grants allowed while instr is waiting
//
// Ports:
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   instr_req_i / instr_addr_i         fetch request channel
//   instr_gnt_o / instr_rvalid_o       fetch grant / response strobe
//   data_req_i, data_we_i, data_be_i,
//   data_addr_i, data_wdata_i          LSU request channel
//   data_gnt_o / data_rvalid_o         LSU grant / response strobe
//   resp_rdata_o, resp_err_o           shared response payload
//   mem_req_o .. mem_wdata_o           shared memory request channel
//   mem_gnt_i, mem_rvalid_i,
//   mem_rdata_i, mem_err_i             shared memory grant / response channel
// ---------------------------------------------------------------------------
module cve2_obi_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned StarveLimit    = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,

    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(MaxOutstanding);

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic                      owner_data;
    logic                      owner_req;
    logic                      grant;
    logic                      push;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      head_data;
    logic                      starve_fire;

    logic [MaxOutstanding-1:0] id_q, id_d;
    logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]           cnt_q, cnt_d;

    // A plain increment would not wrap correctly when the depth is 1, so the
    // wrap point is explicit.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

`ifdef CVE2_ARB_STARVE_GUARD_EN
    localparam int unsigned StarveW = $clog2(StarveLimit + 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(StarveLimit);

    logic [StarveW-1:0] starve_q, starve_d;

    // Count the data grants given while a fetch is waiting. The count
    // saturates, and it clears when the fetch is served or withdrawn.
    always_comb begin
        starve_d = starve_q;
        if (!instr_req_i || instr_gnt_o) begin
            starve_d = '0;
        end else if (data_gnt_o && (starve_q != StarveMax)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign starve_fire = (starve_q == StarveMax);
`else
    assign starve_fire = 1'b0;
`endif

    // Owner select. A held state pins the owner. In ARB, data wins unless
    // the starvation guard has fired and a fetch is waiting.
    always_comb begin
        owner_data = 1'b0;
        unique case (state_q)
            HOLD_I:  owner_data = 1'b0;
            HOLD_D:  owner_data = 1'b1;
            default: owner_data = (starve_fire && instr_req_i) ? 1'b0 : data_req_i;
        endcase
    end

    assign owner_req   = owner_data ? data_req_i : instr_req_i;
    assign mem_req_o   = owner_req & ~fifo_full;
    assign grant       = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = grant & ~owner_data;
    assign data_gnt_o  = grant & owner_data;

    assign mem_we_o    = owner_data ? data_we_i    : 1'b0;
    assign mem_be_o    = owner_data ? data_be_i    : 4'hF;
    assign mem_addr_o  = owner_data ? data_addr_i  : instr_addr_i;
    assign mem_wdata_o = owner_data ? data_wdata_i : 32'h0;

    // Enter a hold when a request is presented but not granted. Leave it on
    // the grant. Also leave it if the held requester withdraws, so a
    // non-compliant master cannot lock up the port.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB: begin
                if (mem_req_o && !mem_gnt_i) begin
                    state_d = owner_data ? HOLD_D : HOLD_I;
                end
            end
            HOLD_I, HOLD_D: begin
                if (grant || !owner_req) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Owner-ID FIFO: 1 = data, 0 = instr. The full flag comes from the
    // registered count, so a pop in the same cycle cannot unblock a new
    // request until the following cycle.
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FullCnt);
    assign push       = grant;
    assign pop        = mem_rvalid_i & ~fifo_empty;
    assign head_data  = id_q[rd_ptr_q];

    always_comb begin
        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            id_d[wr_ptr_q] = owner_data;
            wr_ptr_d       = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Responses return with zero latency to the requester at the FIFO head.
    // A response that arrives while the FIFO is empty is dropped.
    assign instr_rvalid_o = pop & ~head_data;
    assign data_rvalid_o  = pop & head_data;
    assign resp_rdata_o   = mem_rdata_i;
    assign resp_err_o     = mem_err_i;

    // State register, FIFO storage and pointers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ARB;
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    // Flag responses that have no matching outstanding transaction. Such
    // responses are expected after a reset that abandoned in-flight requests.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            assert (MaxOutstanding >= 1 && StarveLimit >= 1)
                else $error("cve2_obi_arbiter: illegal parameter values");
        end else begin
            assert (!(mem_rvalid_i && fifo_empty))
                else $warning("cve2_obi_arbiter: response with no outstanding transaction dropped");
        end
    end
`endif

endmodule

// File: tb/tb_cve2_obi_arbiter.sv
module tb_cve2_obi_arbiter;

    localparam int MaxOut = 2;
    localparam int Limit  = 4;
`ifdef CVE2_ARB_STARVE_GUARD_EN
    localparam bit GuardOn = 1'b1;
`else
    localparam bit GuardOn = 1'b0;
`endif

    logic        clk;
    logic        rstN;
    logic        instrReq;
    logic [31:0] instrAddr;
    logic        instrGnt;
    logic        instrRvalid;
    logic        dataReq;
    logic        dataWe;
    logic [3:0]  dataBe;
    logic [31:0] dataAddr;
    logic [31:0] dataWdata;
    logic        dataGnt;
    logic        dataRvalid;
    logic [31:0] respRdata;
    logic        respErr;
    logic        memReq;
    logic        memWe;
    logic [3:0]  memBe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memGnt;
    logic        memRvalid;
    logic [31:0] memRdata;
    logic        memErr;

    cve2_obi_arbiter #(
        .MaxOutstanding (MaxOut),
        .StarveLimit    (Limit)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .instr_req_i    (instrReq),
        .instr_addr_i   (instrAddr),
        .instr_gnt_o    (instrGnt),
        .instr_rvalid_o (instrRvalid),
        .data_req_i     (dataReq),
        .data_we_i      (dataWe),
        .data_be_i      (dataBe),
        .data_addr_i    (dataAddr),
        .data_wdata_i   (dataWdata),
        .data_gnt_o     (dataGnt),
        .data_rvalid_o  (dataRvalid),
        .resp_rdata_o   (respRdata),
        .resp_err_o     (respErr),
        .mem_req_o      (memReq),
        .mem_we_o       (memWe),
        .mem_be_o       (memBe),
        .mem_addr_o     (memAddr),
        .mem_wdata_o    (memWdata),
        .mem_gnt_i      (memGnt),
        .mem_rvalid_i   (memRvalid),
        .mem_rdata_i    (memRdata),
        .mem_err_i      (memErr)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          memReq;
        bit          instrGnt;
        bit          dataGnt;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          we;
        logic [3:0]  be;
        bit          instrRv;
        bit          dataRv;
        logic [31:0] rdata;
        bit          err;
    } expect_t;

    // Scoreboard and reference model state. The model tracks only abstract
    // facts: the owner of each accepted transaction (in order), who is waiting
    // on an ungranted request, and how many data grants a waiting fetch has
    // seen.
    expect_t cycleQ[$];
    expect_t monE;
    int      outQ[$];
    int      holdOwner;
    int      starve;
    int      errors;
    int      checks;
    bit      lastInstrGnt;
    bit      lastDataGnt;
    bit      recordGrants;
    string   grantSeq;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, predict every DUT output for that cycle with
    // the reference model, queue the prediction, then advance the model.
    task automatic applyStimulus(input bit ir, input logic [31:0] ia,
                                 input bit dr, input bit dwe, input logic [3:0] dbe,
                                 input logic [31:0] da, input logic [31:0] dwd,
                                 input bit gnt, input bit rv,
                                 input logic [31:0] rd, input bit er);
        expect_t e;
        int      owner;
        bit      ownerReq;
        @(posedge clk);
        #1;
        instrReq  = ir;
        instrAddr = ia;
        dataReq   = dr;
        dataWe    = dwe;
        dataBe    = dbe;
        dataAddr  = da;
        dataWdata = dwd;
        memGnt    = gnt;
        memRvalid = rv;
        memRdata  = rd;
        memErr    = er;

        if (holdOwner >= 0) owner = holdOwner;
        else if (GuardOn && starve == Limit && ir) owner = 0;
        else owner = dr ? 1 : 0;
        ownerReq   = (owner == 1) ? dr : ir;
        e.memReq   = ownerReq && (outQ.size() < MaxOut);
        e.instrGnt = e.memReq && gnt && (owner == 0);
        e.dataGnt  = e.memReq && gnt && (owner == 1);
        e.addr     = (owner == 1) ? da : ia;
        e.we       = (owner == 1) ? dwe : 1'b0;
        e.be       = (owner == 1) ? dbe : 4'hF;
        e.wdata    = (owner == 1) ? dwd : 32'h0;
        e.instrRv  = 1'b0;
        e.dataRv   = 1'b0;
        e.rdata    = rd;
        e.err      = er;
        if (rv && outQ.size() > 0) begin
            if (outQ[0] == 1) e.dataRv = 1'b1;
            else e.instrRv = 1'b1;
            void'(outQ.pop_front());
        end
        cycleQ.push_back(e);

        if (e.memReq && gnt) outQ.push_back(owner);
        if (holdOwner < 0) begin
            if (e.memReq && !gnt) holdOwner = owner;
        end else if (e.memReq && gnt) begin
            holdOwner = -1;
        end
        if (GuardOn) begin
            if (!ir || e.instrGnt) starve = 0;
            else if (e.dataGnt && starve < Limit) starve++;
        end
        lastInstrGnt = e.instrGnt;
        lastDataGnt  = e.dataGnt;
    endtask

    task automatic doReset(input int n);
        @(posedge clk);
        #1;
        rstN      = 1'b0;
        instrReq  = 1'b0;
        dataReq   = 1'b0;
        memGnt    = 1'b0;
        memRvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rstN = 1'b1;
        outQ.delete();
        holdOwner = -1;
        starve    = 0;
    endtask

    // Monitor: compares each presented cycle of DUT outputs with the queued
    // prediction, away from the active clock edge.
    always @(negedge clk) begin
        if (cycleQ.size() > 0) begin
            monE = cycleQ.pop_front();
            checkOutput("mem_req_o", {31'b0, memReq}, {31'b0, monE.memReq});
            checkOutput("instr_gnt_o", {31'b0, instrGnt}, {31'b0, monE.instrGnt});
            checkOutput("data_gnt_o", {31'b0, dataGnt}, {31'b0, monE.dataGnt});
            checkOutput("mem_addr_o", memAddr, monE.addr);
            checkOutput("mem_we_o", {31'b0, memWe}, {31'b0, monE.we});
            checkOutput("mem_be_o", {28'b0, memBe}, {28'b0, monE.be});
            checkOutput("mem_wdata_o", memWdata, monE.wdata);
            checkOutput("instr_rvalid_o", {31'b0, instrRvalid}, {31'b0, monE.instrRv});
            checkOutput("data_rvalid_o", {31'b0, dataRvalid}, {31'b0, monE.dataRv});
            if (monE.instrRv || monE.dataRv) begin
                checkOutput("resp_rdata_o", respRdata, monE.rdata);
                checkOutput("resp_err_o", {31'b0, respErr}, {31'b0, monE.err});
            end
            if (recordGrants) begin
                if (dataGnt) grantSeq = {grantSeq, "D"};
                else if (instrGnt) grantSeq = {grantSeq, "I"};
            end
        end
    end

    initial begin
        bit          ip;
        bit          dp;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dbe;
        bit          dwe;
        string       expSeq;

        errors       = 0;
        checks       = 0;
        holdOwner    = -1;
        starve       = 0;
        recordGrants = 1'b0;
        grantSeq     = "";
        rstN         = 1'b0;
        instrReq     = 1'b0;
        instrAddr    = '0;
        dataReq      = 1'b0;
        dataWe       = 1'b0;
        dataBe       = '0;
        dataAddr     = '0;
        dataWdata    = '0;
        memGnt       = 1'b0;
        memRvalid    = 1'b0;
        memRdata     = '0;
        memErr       = 1'b0;

        // Reset state: idle outputs, no responses.
        doReset(3);
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0);

        // Both requesting in ARB: data wins; responses routed in order.
        applyStimulus(1, 32'h1000, 1, 1, 4'h3, 32'h2000, 32'hDEADBEEF, 1, 0, 32'h0, 0);
        applyStimulus(1, 32'h1000, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 32'hCAFE0001, 0);
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hCAFE0002, 1);

        // Instr held without grant while data rises; instr granted in cycle 4.
        applyStimulus(1, 32'h1004, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
        applyStimulus(1, 32'h1004, 1, 0, 4'hF, 32'h3000, 32'h0, 0, 0, 32'h0, 0);
        applyStimulus(1, 32'h1004, 1, 0, 4'hF, 32'h3000, 32'h0, 0, 0, 32'h0, 0);
        applyStimulus(1, 32'h1004, 1, 0, 4'hF, 32'h3000, 32'h0, 1, 0, 32'h0, 0);
        applyStimulus(0, 32'h0, 1, 0, 4'hF, 32'h3000, 32'h0, 1, 1, 32'h11110000, 0);
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h22220000, 0);

        // FIFO full blocks requests; a same-cycle pop unblocks one cycle later.
        applyStimulus(0, 32'h0, 1, 1, 4'hF, 32'h4000, 32'h11, 1, 0, 32'h0, 0);
        applyStimulus(1, 32'h1008, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0, 0);
        applyStimulus(1, 32'h100C, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0, 0);
        applyStimulus(1, 32'h100C, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 32'h33330000, 0);
        applyStimulus(1, 32'h100C, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0, 0);
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h44440000, 0);
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h55550000, 1);

        // Both requesting continuously: grant order shows the starvation guard.
        recordGrants = 1'b1;
        grantSeq     = "";
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, 32'h1010, 1, 0, 4'hF, 32'h5000 + 32'(k * 4), 32'h0,
                          1, (k > 0), 32'h6000 + 32'(k), 0);
        end
        @(negedge clk);
        #1;
        recordGrants = 1'b0;
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h77770000, 0);
        expSeq = GuardOn ? "DDDDIDDDDI" : "DDDDDDDDDD";
        checks++;
        if (grantSeq != expSeq) begin
            errors++;
            $display("[TB] FAIL grant_order: got %s expected %s", grantSeq, expSeq);
        end

        // Reset with two outstanding: late responses are dropped.
        applyStimulus(1, 32'h2000, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0, 0);
        applyStimulus(0, 32'h0, 1, 1, 4'hF, 32'h6000, 32'h77, 1, 0, 32'h0, 0);
        doReset(2);
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h99, 0);
        applyStimulus(0, 32'h0, 1, 0, 4'hF, 32'h6004, 32'h0, 0, 1, 32'h98, 0);
        applyStimulus(0, 32'h0, 1, 0, 4'hF, 32'h6004, 32'h0, 1, 0, 32'h0, 0);
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h88880000, 0);

        // Randomized traffic. Requesters hold each request until it is
        // granted, and memory responds only to transactions it has accepted.
        ip  = 1'b0;
        dp  = 1'b0;
        ia  = '0;
        da  = '0;
        dwd = '0;
        dbe = '0;
        dwe = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!ip) begin
                ip = ($urandom_range(0, 2) == 0);
                ia = $urandom & 32'hFFFF_FFFC;
            end
            if (!dp) begin
                dp  = ($urandom_range(0, 1) == 0);
                da  = $urandom;
                dwd = $urandom;
                dbe = 4'($urandom);
                dwe = ($urandom_range(0, 1) == 1);
            end
            applyStimulus(ip, ia, dp, dwe, dbe, da, dwd,
                          ($urandom_range(0, 3) != 0),
                          (outQ.size() > 0) && ($urandom_range(0, 1) == 1),
                          $urandom, ($urandom_range(0, 7) == 0));
            if (lastInstrGnt) ip = 1'b0;
            if (lastDataGnt) dp = 1'b0;
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
